periph_bridge: RTL and testbench

- CPU-side initiator for the memory-mapped peripheral bus; the timer/counter devices are responders on that bus.
- Decodes CPU byte addresses onto two timer/counter slots plus bridge-internal interrupt registers.
- Sequences each access through a req/ready handshake and returns registered read data.
- Edge-captures device IRQ lines into write-1-to-clear pending bits and presents masked hardware interrupt lines to the CPU exception logic.

---
 rtl/periph_bridge_pkg.sv | 60 ++++++
 rtl/periph_bridge_if.sv | 26 ++
 rtl/periph_bridge_irq_capture.sv | 58 +++++
 rtl/periph_bridge.sv | 136 +++++++++++++
 tb/tb_periph_bridge.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/periph_bridge_pkg.sv
// periph_bridge_pkg: definitions shared by the peripheral bridge and its
// interrupt-capture block.
//   state_t        - bridge access FSM encoding (STATE_IDLE/ACCESS/RESP)
//   sel_t          - address decode result
//   *_BASE_DEF     - default byte base addresses of the decoded windows
//   IRQ_*          - bit positions of the interrupt sources in PEND/MASK/hwint
//   PEND_OFF/MASK_OFF - byte offsets of the bridge registers from IRQ_BASE
//   decode()       - maps a word address onto a target
package periph_bridge_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_ACCESS = 2'd1,
        STATE_RESP   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_TC0  = 3'd1,
        SEL_TC1  = 3'd2,
        SEL_PEND = 3'd3,
        SEL_MASK = 3'd4
    } sel_t;

    localparam logic [31:0] TC0_BASE_DEF = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE_DEF = 32'h0000_7F10;
    localparam logic [31:0] IRQ_BASE_DEF = 32'h0000_7F20;

    localparam int IRQ_TC0 = 0;
    localparam int IRQ_TC1 = 1;
    localparam int IRQ_EXT = 2;

    localparam int PEND_OFF = 0;
    localparam int MASK_OFF = 4;

    // Each timer window holds three words (ctrl, preset, count); the fourth
    // word of the 16-byte stride is deliberately left unmapped. The unsigned
    // subtraction wraps for addresses below the base, so one compare covers
    // both ends of the window.
    function automatic sel_t decode(input logic [29:0] word,
                                    input logic [29:0] tc0_word,
                                    input logic [29:0] tc1_word,
                                    input logic [29:0] irq_word);
        logic [29:0] off0;
        logic [29:0] off1;
        off0 = word - tc0_word;
        off1 = word - tc1_word;
        if (off0 < 30'd3)
            return SEL_TC0;
        else if (off1 < 30'd3)
            return SEL_TC1;
        else if (word == irq_word + 30'(PEND_OFF / 4))
            return SEL_PEND;
        else if (word == irq_word + 30'(MASK_OFF / 4))
            return SEL_MASK;
        else
            return SEL_NONE;
    endfunction

endpackage

// File: rtl/periph_bridge_if.sv
// periph_bridge_if: CPU-side request/response bus of the peripheral bridge.
//   req/addr/we/wdata - request, driven by the CPU (master)
//   ready/rdata/err   - completion, driven by the bridge (slave)
// Handshake: the master raises req with addr/we/wdata and holds all four
// stable until it sees ready=1. ready is a single-cycle pulse; rdata and err
// are only meaningful in that cycle. The bridge samples req only while idle,
// so req may already be high again during the ready cycle.
interface periph_bridge_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, we, wdata,
        input  ready, rdata, err
    );

    modport slave (
        input  req, addr, we, wdata,
        output ready, rdata, err
    );
endinterface

// File: rtl/periph_bridge_irq_capture.sv
// periph_bridge_irq_capture: rising-edge capture of device interrupt lines
// into write-1-to-clear pending bits, a mask register, and the masked
// hardware interrupt vector to the CPU.
//   clk, reset           - clock, async active-high reset
//   tc0_irq/tc1_irq/ext_irq - device interrupt levels
//   pend_wr, mask_wr     - register write strobes (one cycle)
//   wr_data              - low three bits of the write data
//   pend, mask           - register contents (for bus reads)
//   hwint                - {3'b000, pend & mask}
module periph_bridge_irq_capture
    import periph_bridge_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tc0_irq,
    input  logic       tc1_irq,
    input  logic       ext_irq,
    input  logic       pend_wr,
    input  logic       mask_wr,
    input  logic [2:0] wr_data,
    output logic [2:0] pend,
    output logic [2:0] mask,
    output logic [5:0] hwint
);

    logic [2:0] irq_in;
    logic [2:0] irq_q;
    logic [2:0] rise;
    logic [2:0] clr;

    always_comb begin
        irq_in          = '0;
        irq_in[IRQ_TC0] = tc0_irq;
        irq_in[IRQ_TC1] = tc1_irq;
        irq_in[IRQ_EXT] = ext_irq;
    end

    assign rise = irq_in & ~irq_q;
    assign clr  = pend_wr ? wr_data : 3'b000;

    // Clear is applied before set so a new edge arriving with a W1C write
    // of the same bit is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= '0;
            pend  <= '0;
            mask  <= 3'b111;
        end else begin
            irq_q <= irq_in;
            pend  <= (pend & ~clr) | rise;
            if (mask_wr)
                mask <= wr_data;
        end
    end

    assign hwint = {3'b000, pend & mask};

endmodule

// File: rtl/periph_bridge.sv
// periph_bridge: CPU-side initiator for the memory-mapped peripheral bus.
// Decodes CPU byte addresses onto two timer/counter windows and the bridge's
// own PEND/MASK registers, runs each access as IDLE -> ACCESS -> RESP, and
// returns registered read data with a one-cycle ready pulse.
//   clk, reset          - clock, async active-high reset
//   cpu                 - CPU request/response bus (slave side)
//   dev_addr, dev_wdata - word address and write data to the devices
//   tc0_we, tc1_we      - device write strobes, high for the ACCESS cycle
//   tc0_rdata, tc1_rdata - combinational device read data
//   tc0_irq, tc1_irq, ext_irq - device interrupt levels
//   hwint               - masked hardware interrupt lines
//   state_dbg           - current FSM state
module periph_bridge
    import periph_bridge_pkg::*;
#(
    parameter logic [31:0] TC0_BASE = TC0_BASE_DEF,
    parameter logic [31:0] TC1_BASE = TC1_BASE_DEF,
    parameter logic [31:0] IRQ_BASE = IRQ_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    periph_bridge_if.slave cpu,
    output logic [29:0] dev_addr,
    output logic [31:0] dev_wdata,
    output logic        tc0_we,
    output logic        tc1_we,
    input  logic [31:0] tc0_rdata,
    input  logic [31:0] tc1_rdata,
    input  logic        tc0_irq,
    input  logic        tc1_irq,
    input  logic        ext_irq,
    output logic [5:0]  hwint,
    output state_t      state_dbg
);

    state_t      state;
    sel_t        sel_d;
    sel_t        sel_q;
    logic        we_q;
    logic [31:0] rd_mux;
    logic [2:0]  pend;
    logic [2:0]  mask;
    logic        pend_wr;
    logic        mask_wr;
    logic        unused_addr_bits;

    // Byte-lane bits play no part in decode or in the device word address.
    assign unused_addr_bits = ^cpu.addr[1:0];

    assign sel_d = decode(cpu.addr[31:2], TC0_BASE[31:2], TC1_BASE[31:2],
                          IRQ_BASE[31:2]);

    assign pend_wr = (state == STATE_ACCESS) && we_q && (sel_q == SEL_PEND);
    assign mask_wr = (state == STATE_ACCESS) && we_q && (sel_q == SEL_MASK);

    always_comb begin
        rd_mux = '0;
        case (sel_q)
            SEL_TC0:  rd_mux = tc0_rdata;
            SEL_TC1:  rd_mux = tc1_rdata;
            SEL_PEND: rd_mux = {29'b0, pend};
            SEL_MASK: rd_mux = {29'b0, mask};
            default:  rd_mux = '0;
        endcase
    end

    // dev_addr/dev_wdata are loaded on acceptance, so they are already
    // stable while the strobe is high in ACCESS. ready and the strobes
    // default low every cycle and are only raised on the transition that
    // opens the cycle they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= STATE_IDLE;
            cpu.ready <= 1'b0;
            cpu.rdata <= '0;
            cpu.err   <= 1'b0;
            tc0_we    <= 1'b0;
            tc1_we    <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            sel_q     <= SEL_NONE;
            we_q      <= 1'b0;
        end else begin
            cpu.ready <= 1'b0;
            tc0_we    <= 1'b0;
            tc1_we    <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (cpu.req) begin
                        we_q  <= cpu.we;
                        sel_q <= sel_d;
                        if (sel_d == SEL_NONE) begin
                            state     <= STATE_RESP;
                            cpu.ready <= 1'b1;
                            cpu.err   <= 1'b1;
                            cpu.rdata <= '0;
                        end else begin
                            state     <= STATE_ACCESS;
                            dev_addr  <= cpu.addr[31:2];
                            dev_wdata <= cpu.wdata;
                            tc0_we    <= cpu.we && (sel_d == SEL_TC0);
                            tc1_we    <= cpu.we && (sel_d == SEL_TC1);
                        end
                    end
                end
                STATE_ACCESS: begin
                    cpu.rdata <= we_q ? '0 : rd_mux;
                    cpu.ready <= 1'b1;
                    state     <= STATE_RESP;
                end
                STATE_RESP: begin
                    cpu.err <= 1'b0;
                    state   <= STATE_IDLE;
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

    periph_bridge_irq_capture u_irq (
        .clk     (clk),
        .reset   (reset),
        .tc0_irq (tc0_irq),
        .tc1_irq (tc1_irq),
        .ext_irq (ext_irq),
        .pend_wr (pend_wr),
        .mask_wr (mask_wr),
        .wr_data (dev_wdata[2:0]),
        .pend    (pend),
        .mask    (mask),
        .hwint   (hwint)
    );

    assign state_dbg = state;

endmodule

// File: tb/tb_periph_bridge.sv
// tb_periph_bridge: directed bench for periph_bridge with a scoreboard of
// expected bus responses.
module tb_periph_bridge;
    import periph_bridge_pkg::*;

    logic        clk;
    logic        reset;
    logic [29:0] dev_addr;
    logic [31:0] dev_wdata;
    logic        tc0_we;
    logic        tc1_we;
    logic [31:0] tc0_rdata;
    logic [31:0] tc1_rdata;
    logic        tc0_irq;
    logic        tc1_irq;
    logic        ext_irq;
    logic [5:0]  hwint;
    state_t      state_dbg;

    periph_bridge_if cpu ();

    periph_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (cpu),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .tc0_we    (tc0_we),
        .tc1_we    (tc1_we),
        .tc0_rdata (tc0_rdata),
        .tc1_rdata (tc1_rdata),
        .tc0_irq   (tc0_irq),
        .tc1_irq   (tc1_irq),
        .ext_irq   (ext_irq),
        .hwint     (hwint),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    // {is_read, err, rdata}
    logic [33:0] exp_q[$];
    string       cur_tag = "none";
    int          tc0_we_cnt = 0;
    int          tc1_we_cnt = 0;
    int          ready_cnt  = 0;
    logic [29:0] seen_addr  = '0;
    logic [31:0] seen_wdata = '0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (tc0_we) begin
            tc0_we_cnt++;
            seen_addr  = dev_addr;
            seen_wdata = dev_wdata;
        end
        if (tc1_we) begin
            tc1_we_cnt++;
            seen_addr  = dev_addr;
            seen_wdata = dev_wdata;
        end
        if (cpu.ready) begin
            logic [33:0] e;
            ready_cnt++;
            check({cur_tag, "/ready_expected"}, {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({cur_tag, "/err"}, {31'b0, cpu.err}, {31'b0, e[32]});
                if (e[33])
                    check({cur_tag, "/rdata"}, cpu.rdata, e[31:0]);
            end
        end
    end

    // ---------------- driver ----------------
    // Called #1 after a rising edge; returns #1 after the edge that takes
    // the bridge back to IDLE.
    task automatic bus_access(input string tag, input logic [31:0] addr,
                              input logic we, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input logic raise_tc1);
        int lat;
        bit done;
        cur_tag = tag;
        exp_q.push_back({~we, exp_err, exp_rdata});
        tc0_we_cnt = 0;
        tc1_we_cnt = 0;
        cpu.req   = 1'b1;
        cpu.addr  = addr;
        cpu.we    = we;
        cpu.wdata = wdata;
        lat  = 0;
        done = 0;
        while (!done && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            if (raise_tc1 && lat == 1)
                tc1_irq = 1'b1;
            if (cpu.ready)
                done = 1;
        end
        cpu.req = 1'b0;
        check({tag, "/latency"}, lat, exp_lat);
        if (!done)
            void'(exp_q.pop_back());
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        cpu.req   = 1'b0;
        cpu.addr  = '0;
        cpu.we    = 1'b0;
        cpu.wdata = '0;
        tc0_rdata = 32'h1234_5678;
        tc1_rdata = 32'hDEAD_BEEF;
        tc0_irq   = 1'b0;
        tc1_irq   = 1'b0;
        ext_irq   = 1'b0;

        // reset values
        @(posedge clk);
        #1;
        check("rst/ready", {31'b0, cpu.ready}, 32'd0);
        check("rst/rdata", cpu.rdata, 32'd0);
        check("rst/err", {31'b0, cpu.err}, 32'd0);
        check("rst/we", {30'b0, tc1_we, tc0_we}, 32'd0);
        check("rst/dev_addr", {2'b0, dev_addr}, 32'd0);
        check("rst/dev_wdata", dev_wdata, 32'd0);
        check("rst/hwint", {26'b0, hwint}, 32'd0);
        check("rst/state", {30'b0, state_dbg}, {30'b0, STATE_IDLE});
        reset = 1'b0;
        cycles(2);

        // timer 0 write
        bus_access("wr_tc0", 32'h0000_7F04, 1'b1, 32'h0000_0010, '0, 1'b0, 2, 1'b0);
        check("wr_tc0/tc0_strobes", tc0_we_cnt, 1);
        check("wr_tc0/tc1_strobes", tc1_we_cnt, 0);
        check("wr_tc0/dev_addr", {2'b0, seen_addr}, 32'h0000_1FC1);
        check("wr_tc0/dev_wdata", seen_wdata, 32'h0000_0010);

        // timer reads
        bus_access("rd_tc1", 32'h0000_7F18, 1'b0, '0, 32'hDEAD_BEEF, 1'b0, 2, 1'b0);
        check("rd_tc1/strobes", tc0_we_cnt + tc1_we_cnt, 0);
        bus_access("rd_tc0", 32'h0000_7F00, 1'b0, '0, 32'h1234_5678, 1'b0, 2, 1'b0);

        // unmapped
        bus_access("rd_7f0c", 32'h0000_7F0C, 1'b0, '0, 32'd0, 1'b1, 1, 1'b0);
        check("rd_7f0c/strobes", tc0_we_cnt + tc1_we_cnt, 0);
        bus_access("wr_8000", 32'h0000_8000, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 1'b0);
        check("wr_8000/strobes", tc0_we_cnt + tc1_we_cnt, 0);
        bus_access("rd_8000", 32'h0000_8000, 1'b0, '0, 32'd0, 1'b1, 1, 1'b0);

        // bridge registers after reset
        bus_access("rd_mask_rst", 32'h0000_7F24, 1'b0, '0, 32'd7, 1'b0, 2, 1'b0);
        bus_access("rd_pend_rst", 32'h0000_7F20, 1'b0, '0, 32'd0, 1'b0, 2, 1'b0);

        // random timer reads
        for (int i = 0; i < 4; i++) begin
            logic [31:0] data;
            logic [31:0] a;
            int slot;
            data = $urandom;
            slot = $urandom_range(0, 1);
            a = (slot == 0 ? 32'h0000_7F00 : 32'h0000_7F10)
                + 32'($urandom_range(0, 2) * 4);
            if (slot == 0) tc0_rdata = data;
            else           tc1_rdata = data;
            bus_access("rd_rand", a, 1'b0, '0, data, 1'b0, 2, 1'b0);
            check("rd_rand/strobes", tc0_we_cnt + tc1_we_cnt, 0);
        end

        // level held high sets once; W1C sticks until a new edge
        tc0_irq = 1'b1;
        cycles(20);
        check("irq_hold/hwint", {26'b0, hwint}, 32'h01);
        bus_access("rd_pend_1", 32'h0000_7F20, 1'b0, '0, 32'd1, 1'b0, 2, 1'b0);
        bus_access("w1c_pend_0", 32'h0000_7F20, 1'b1, 32'd1, '0, 1'b0, 2, 1'b0);
        check("w1c/hwint", {26'b0, hwint}, 32'h00);
        cycles(5);
        check("w1c_held/hwint", {26'b0, hwint}, 32'h00);
        tc0_irq = 1'b0;
        cycles(2);
        check("irq_low/hwint", {26'b0, hwint}, 32'h00);
        tc0_irq = 1'b1;
        cycles(2);
        check("irq_reraise/hwint", {26'b0, hwint}, 32'h01);
        tc0_irq = 1'b0;
        bus_access("w1c_pend_0b", 32'h0000_7F20, 1'b1, 32'd1, '0, 1'b0, 2, 1'b0);
        check("w1c_b/hwint", {26'b0, hwint}, 32'h00);

        // masking
        bus_access("wr_mask_2", 32'h0000_7F24, 1'b1, 32'hFFFF_FFFA, '0, 1'b0, 2, 1'b0);
        tc0_irq = 1'b1;
        tc1_irq = 1'b1;
        cycles(1);
        tc0_irq = 1'b0;
        tc1_irq = 1'b0;
        cycles(2);
        check("mask/hwint", {26'b0, hwint}, 32'h02);
        bus_access("rd_pend_3", 32'h0000_7F20, 1'b0, '0, 32'd3, 1'b0, 2, 1'b0);
        bus_access("rd_pend_3b", 32'h0000_7F20, 1'b0, '0, 32'd3, 1'b0, 2, 1'b0);
        bus_access("rd_mask_2", 32'h0000_7F24, 1'b0, '0, 32'd2, 1'b0, 2, 1'b0);

        // set beats W1C in the same cycle
        bus_access("w1c_all", 32'h0000_7F20, 1'b1, 32'd7, '0, 1'b0, 2, 1'b0);
        check("w1c_all/hwint", {26'b0, hwint}, 32'h00);
        bus_access("w1c_race", 32'h0000_7F20, 1'b1, 32'd2, '0, 1'b0, 2, 1'b1);
        bus_access("rd_pend_race", 32'h0000_7F20, 1'b0, '0, 32'd2, 1'b0, 2, 1'b0);
        check("race/hwint", {26'b0, hwint}, 32'h02);

        // ext source, masked then unmasked
        ext_irq = 1'b1;
        cycles(2);
        check("ext_masked/hwint", {26'b0, hwint}, 32'h02);
        bus_access("rd_pend_6", 32'h0000_7F20, 1'b0, '0, 32'd6, 1'b0, 2, 1'b0);
        bus_access("wr_mask_7", 32'h0000_7F24, 1'b1, 32'd7, '0, 1'b0, 2, 1'b0);
        check("ext_unmasked/hwint", {26'b0, hwint}, 32'h06);
        tc1_irq = 1'b0;
        ext_irq = 1'b0;
        bus_access("wr_mask_1", 32'h0000_7F24, 1'b1, 32'd1, '0, 1'b0, 2, 1'b0);
        check("mask_1/hwint", {26'b0, hwint}, 32'h00);
        cycles(2);

        // async reset during the ACCESS cycle of a timer write
        cur_tag = "rst_mid";
        tc1_we_cnt = 0;
        cpu.req   = 1'b1;
        cpu.addr  = 32'h0000_7F10;
        cpu.we    = 1'b1;
        cpu.wdata = 32'h0000_00AA;
        @(posedge clk);
        #1;
        check("rst_mid/state", {30'b0, state_dbg}, {30'b0, STATE_ACCESS});
        check("rst_mid/tc1_we_before", {31'b0, tc1_we}, 32'd1);
        ready_cnt = 0;
        reset = 1'b1;
        #1;
        check("rst_mid/tc1_we_after", {31'b0, tc1_we}, 32'd0);
        check("rst_mid/state_idle", {30'b0, state_dbg}, {30'b0, STATE_IDLE});
        @(posedge clk);
        #1;
        cpu.req = 1'b0;
        reset   = 1'b0;
        cycles(5);
        check("rst_mid/ready_pulses", ready_cnt, 0);
        check("rst_mid/tc1_strobes", tc1_we_cnt, 0);
        check("rst_mid/hwint", {26'b0, hwint}, 32'h00);
        bus_access("rst_mid/rd_mask", 32'h0000_7F24, 1'b0, '0, 32'd7, 1'b0, 2, 1'b0);
        bus_access("rst_mid/rd_pend", 32'h0000_7F20, 1'b0, '0, 32'd0, 1'b0, 2, 1'b0);

        cycles(2);
        check("end/queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
